// File: rtl/mem_stage_mc.sv
// Multi-cycle data-memory stage: serialises loads/stores into a DEPTH-word array,
// stalling the pipeline for LATENCY cycles and rejecting malformed requests via err.
module mem_stage_mc #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 8,
  parameter int ALIGN_LOG2 = 1,
  parameter int LATENCY    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int IDX_TOP = ALIGN_LOG2 + DEPTH_LOG2;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << ALIGN_LOG2) - 1);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [DATA_W-1:0]     r_wdata;
  logic                  r_write;
  logic                  r_err;
  logic [DATA_W-1:0]     r_rdata;
  logic [DATA_W-1:0]     r_mem [0:DEPTH-1];

  logic                  w_req;
  logic                  w_bad;
  logic                  w_access;
  logic [DEPTH_LOG2-1:0] w_idx;

  assign w_req    = mem_read | mem_write;
  assign w_idx    = addr[ALIGN_LOG2 +: DEPTH_LOG2];
  assign w_bad    = ((addr & ALIGN_MASK) != '0)
                  | ((addr >> IDX_TOP) != '0)
                  | (mem_read & mem_write);
  assign w_access = (r_state == BUSY) && (r_cnt == 4'd0);

  // Outputs are forced low while reset is held, even if a request is still presented.
  assign stall = rst & (((r_state == IDLE) & w_req) | (r_state == BUSY));
  assign done  = rst & (r_state == DONE);
  assign err   = done & r_err;
  assign rdata = r_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req && w_bad) begin
            r_err   <= 1'b1;
            r_state <= DONE;
          end else if (w_req) begin
            r_idx   <= w_idx;
            r_wdata <= wdata;
            r_write <= mem_write;
            r_cnt   <= CNT_LOAD;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt == 4'd0) begin
            if (!r_write) r_rdata <= r_mem[r_idx];
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        DONE: begin
          r_err   <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // The array has no reset; reset forces IDLE so an abandoned store can never land.
  always_ff @(posedge clk) begin
    if (w_access && r_write) r_mem[r_idx] <= r_wdata;
  end

endmodule
